// File: rtl/subtractor_nbit_serial.sv
// Bit-serial N-bit subtractor (a - b - borrow_in), LSB first, with valid/ready on both sides.
// Optional compare flags (o_zero/o_ltu/o_lts) when SUBTRACTOR_NBIT_SERIAL_CMP_EN is defined.
module subtractor_nbit_serial #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_vld,
   output logic                  o_rdy,
   input  logic [DATA_WIDTH-1:0] i_num_a,
   input  logic [DATA_WIDTH-1:0] i_num_b,
   input  logic                  i_brw,
   output logic                  o_vld,
   input  logic                  i_rdy,
   output logic [DATA_WIDTH-1:0] o_res,
   output logic                  o_brw,
   output logic                  o_ovf
`ifdef SUBTRACTOR_NBIT_SERIAL_CMP_EN
   ,
   output logic                  o_zero,
   output logic                  o_ltu,
   output logic                  o_lts
`endif
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic                  brw_q;
   logic                  ovf_q;
   logic                  vld_q;
`ifdef SUBTRACTOR_NBIT_SERIAL_CMP_EN
   logic                  zero_q;
   logic                  ltu_q;
   logic                  lts_q;
`endif

   logic                  bit_a;
   logic                  bit_b;
   logic                  diff;
   logic                  brw_next;
   logic                  ovf_next;
   logic [DATA_WIDTH-1:0] res_shift;

   // Operands shift right, so bit 0 is always the bit under process.
   always_comb begin
      bit_a     = a_q[0];
      bit_b     = b_q[0];
      diff      = bit_a ^ bit_b ^ brw_q;
      brw_next  = (~bit_a & bit_b) | (~bit_a & brw_q) | (bit_b & brw_q);
      res_shift = {diff, res_q[DATA_WIDTH-1:1]};
      // Only meaningful on the MSB step, where bit_a/bit_b are the operand sign bits.
      ovf_next  = (bit_a != bit_b) & (diff != bit_a);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         brw_q   <= 1'b0;
         ovf_q   <= 1'b0;
         vld_q   <= 1'b0;
`ifdef SUBTRACTOR_NBIT_SERIAL_CMP_EN
         zero_q  <= 1'b0;
         ltu_q   <= 1'b0;
         lts_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_vld) begin
                  a_q     <= i_num_a;
                  b_q     <= i_num_b;
                  brw_q   <= i_brw;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= StCalc;
               end
            end
            StCalc: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               res_q <= res_shift;
               brw_q <= brw_next;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  ovf_q   <= ovf_next;
                  vld_q   <= 1'b1;
                  state_q <= StDone;
`ifdef SUBTRACTOR_NBIT_SERIAL_CMP_EN
                  zero_q  <= (res_shift == '0);
                  ltu_q   <= brw_next;
                  lts_q   <= diff ^ ovf_next;
`endif
               end
            end
            StDone: begin
               if (i_rdy) begin
                  vld_q   <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               vld_q   <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      o_rdy = (state_q == StIdle);
      o_vld = vld_q;
      o_res = vld_q ? res_q : '0;
      o_brw = vld_q & brw_q;
      o_ovf = vld_q & ovf_q;
`ifdef SUBTRACTOR_NBIT_SERIAL_CMP_EN
      o_zero = vld_q & zero_q;
      o_ltu  = vld_q & ltu_q;
      o_lts  = vld_q & lts_q;
`endif
   end

endmodule

// File: tb/tb_subtractor_nbit_serial.sv
// Bench for subtractor_nbit_serial: directed 8-bit vectors and corner sequences, 32-bit random sweep.
module tb_subtractor_nbit_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // 8-bit instance
   logic       vld8, rdy8, brwi8, ovld8, irdy8, obrw8, ovf8;
   logic [7:0] a8, b8, res8;
   // 32-bit instance
   logic        vld32, rdy32, brwi32, ovld32, irdy32, obrw32, ovf32;
   logic [31:0] a32, b32, res32;
`ifdef SUBTRACTOR_NBIT_SERIAL_CMP_EN
   logic zero8, ltu8, lts8, zero32, ltu32, lts32;
`endif

   subtractor_nbit_serial #(.DATA_WIDTH(8)) u_dut8 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_vld   (vld8),
      .o_rdy   (rdy8),
      .i_num_a (a8),
      .i_num_b (b8),
      .i_brw   (brwi8),
      .o_vld   (ovld8),
      .i_rdy   (irdy8),
      .o_res   (res8),
      .o_brw   (obrw8),
      .o_ovf   (ovf8)
`ifdef SUBTRACTOR_NBIT_SERIAL_CMP_EN
      ,
      .o_zero  (zero8),
      .o_ltu   (ltu8),
      .o_lts   (lts8)
`endif
   );

   subtractor_nbit_serial #(.DATA_WIDTH(32)) u_dut32 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_vld   (vld32),
      .o_rdy   (rdy32),
      .i_num_a (a32),
      .i_num_b (b32),
      .i_brw   (brwi32),
      .o_vld   (ovld32),
      .i_rdy   (irdy32),
      .o_res   (res32),
      .o_brw   (obrw32),
      .o_ovf   (ovf32)
`ifdef SUBTRACTOR_NBIT_SERIAL_CMP_EN
      ,
      .o_zero  (zero32),
      .o_ltu   (ltu32),
      .o_lts   (lts32)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bi;
      logic [7:0] res;
      logic       brw;
      logic       ovf;
      logic       zero;
      logic       ltu;
      logic       lts;
   } vec_t;

   vec_t vecs[7];

   // Issue one 8-bit operation; returns edges from accept until o_vld is seen (100 = timed out).
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int lat);
      @(negedge clk);
      check("rdy8_before_accept", 32'(rdy8), 32'd1);
      a8 = a; b8 = b; brwi8 = bi; vld8 = 1'b1;
      @(posedge clk);
      #1;
      vld8 = 1'b0;
      // Operands must be ignored once accepted.
      a8 = 8'($urandom); b8 = 8'($urandom); brwi8 = 1'($urandom);
      lat = 0;
      while (!ovld8 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release8();
      @(negedge clk);
      irdy8 = 1'b1;
      @(posedge clk);
      #1;
      irdy8 = 1'b0;
      check("rel8_vld", 32'(ovld8), 32'd0);
      check("rel8_rdy", 32'(rdy8), 32'd1);
   endtask

   task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic bi, output int lat);
      @(negedge clk);
      a32 = a; b32 = b; brwi32 = bi; vld32 = 1'b1;
      @(posedge clk);
      #1;
      vld32 = 1'b0;
      a32 = $urandom; b32 = $urandom; brwi32 = 1'($urandom);
      lat = 0;
      while (!ovld32 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Reference: plain (W+1)-bit arithmetic.
   function automatic void model32(input logic [31:0] a, input logic [31:0] b, input logic bi,
                                   output logic [31:0] res, output logic brw, output logic ovf);
      logic [32:0] full;
      full = {1'b0, a} - {1'b0, b} - 33'(bi);
      res  = full[31:0];
      brw  = full[32];
      ovf  = (a[31] != b[31]) && (res[31] != a[31]);
   endfunction

   initial begin
      int lat;
      logic [31:0] ra, rb, eres;
      logic rbi, ebrw, eovf;

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

      rst_n = 1'b0;
      vld8 = 1'b0; irdy8 = 1'b0; a8 = '0; b8 = '0; brwi8 = 1'b0;
      vld32 = 1'b0; irdy32 = 1'b0; a32 = '0; b32 = '0; brwi32 = 1'b0;

      #12;
      check("rst_rdy8", 32'(rdy8), 32'd1);
      check("rst_vld8", 32'(ovld8), 32'd0);
      check("rst_res8", 32'(res8), 32'd0);
      check("rst_brw8", 32'(obrw8), 32'd0);
      check("rst_ovf8", 32'(ovf8), 32'd0);
      check("rst_rdy32", 32'(rdy32), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         op8(vecs[i].a, vecs[i].b, vecs[i].bi, lat);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'd8);
         check($sformatf("vec%0d_res", i), 32'(res8), 32'(vecs[i].res));
         check($sformatf("vec%0d_brw", i), 32'(obrw8), 32'(vecs[i].brw));
         check($sformatf("vec%0d_ovf", i), 32'(ovf8), 32'(vecs[i].ovf));
`ifdef SUBTRACTOR_NBIT_SERIAL_CMP_EN
         check($sformatf("vec%0d_zero", i), 32'(zero8), 32'(vecs[i].zero));
         check($sformatf("vec%0d_ltu", i), 32'(ltu8), 32'(vecs[i].ltu));
         check($sformatf("vec%0d_lts", i), 32'(lts8), 32'(vecs[i].lts));
`endif
         release8();
      end

      // Backpressure: DONE holds, ignores new operands and i_vld.
      op8(8'h05, 8'h03, 1'b0, lat);
      check("bp_lat", 32'(lat), 32'd8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom); brwi8 = 1'($urandom); vld8 = 1'b1;
         @(posedge clk);
         #1;
         check("bp_vld", 32'(ovld8), 32'd1);
         check("bp_res", 32'(res8), 32'h02);
         check("bp_brw", 32'(obrw8), 32'd0);
         check("bp_rdy", 32'(rdy8), 32'd0);
      end
      @(negedge clk);
      vld8 = 1'b0;
      irdy8 = 1'b1;
      @(posedge clk);
      #1;
      irdy8 = 1'b0;
      check("bp_rel_vld", 32'(ovld8), 32'd0);
      check("bp_rel_rdy", 32'(rdy8), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("bp_idle_rdy", 32'(rdy8), 32'd1);
      check("bp_idle_vld", 32'(ovld8), 32'd0);

      // Reset mid-CALC after three bits.
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h11; brwi8 = 1'b0; vld8 = 1'b1;
      @(posedge clk);
      #1;
      vld8 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_rdy", 32'(rdy8), 32'd1);
      check("mid_rst_vld", 32'(ovld8), 32'd0);
      check("mid_rst_res", 32'(res8), 32'd0);
      check("mid_rst_brw", 32'(obrw8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op8(8'h10, 8'h01, 1'b0, lat);
      check("post_rst_lat", 32'(lat), 32'd8);
      check("post_rst_res", 32'(res8), 32'h0F);
      check("post_rst_brw", 32'(obrw8), 32'd0);
      release8();

      // 32-bit random sweep with random consumer stalls.
      for (int i = 0; i < 1000; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rbi = 1'($urandom_range(0, 1));
         if (i == 0) begin
            ra = 32'h8000_0000; rb = 32'h0000_0001; rbi = 1'b0;
         end
         model32(ra, rb, rbi, eres, ebrw, eovf);
         op32(ra, rb, rbi, lat);
         check("rnd_lat", 32'(lat), 32'd32);
         check("rnd_res", res32, eres);
         check("rnd_brw", 32'(obrw32), 32'(ebrw));
         check("rnd_ovf", 32'(ovf32), 32'(eovf));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         check("rnd_held_res", res32, eres);
         @(negedge clk);
         irdy32 = 1'b1;
         @(posedge clk);
         #1;
         irdy32 = 1'b0;
         check("rnd_rel_vld", 32'(ovld32), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/subtractor_nbit_serial.md
Name: subtractor_nbit_serial

Overview:
- Multi-cycle, bit-serial N-bit subtractor: computes a - b - borrow_in, LSB first, one bit per clock.
- Per bit: difference = a ^ b ^ br; next borrow = (~a & b) | (~a & br) | (b & br).
- Serves as the area-minimal subtract/compare path beside the full-adder-based arithmetic in the common arithmetic library.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; legal range >= 2.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_vld  input  1  operand valid.
- o_rdy  output  1  operand ready; high only in IDLE.
- i_num_a  input  DATA_WIDTH  minuend.
- i_num_b  input  DATA_WIDTH  subtrahend.
- i_brw  input  1  borrow in.
- o_vld  output  1  result valid.
- i_rdy  input  1  result ready (consumer).
- o_res  output  DATA_WIDTH  difference.
- o_brw  output  1  borrow out of the MSB (unsigned a < b + i_brw).
- o_ovf  output  1  signed overflow.

Behaviour:
- Interface: one clock, i_clk; reset is asynchronous and active-low, i_rst_n.
- FSM states: IDLE, CALC, DONE.
- Reset (async assert): state -> IDLE, bit counter = 0, operand/result shift registers = 0, borrow FF = 0.
- Output reset values: o_vld = 0, o_res = 0, o_brw = 0, o_ovf = 0, o_rdy = 1.
- o_rdy = (state == IDLE), combinational from state.
- IDLE -> CALC:
  - Accept on the edge where i_vld & o_rdy.
  - Latch i_num_a, i_num_b, i_brw; clear counter.
  - i_vld with no accept has no effect.
- CALC:
  - Each edge: process bit [counter] from the LSB of the operand shift registers.
  - Shift the difference bit into the MSB of the result register; update borrow FF; counter++.
  - On the edge where counter == DATA_WIDTH-1: go to DONE and capture the MSB values needed for o_ovf.
- Latency: accept at edge t -> o_vld = 1 after edge t+DATA_WIDTH.
- DONE:
  - o_vld = 1; o_res, o_brw, o_ovf driven and held stable.
  - On the edge where i_rdy = 1: -> IDLE.
  - i_rdy = 0 holds DONE indefinitely; outputs stay unchanged.
- Throughput: no accept during DONE, even if i_rdy is high. Minimum issue interval is DATA_WIDTH+2 cycles.
- Inputs: i_num_a, i_num_b, i_brw and i_vld are ignored outside IDLE; operand changes mid-operation do not affect the result.
- Output gating: o_res, o_brw and o_ovf are forced to 0 whenever o_vld = 0.
- Arithmetic:
  - {o_brw, o_res} equals the (DATA_WIDTH+1)-bit two's-complement result of a - b - i_brw, with o_brw = 1 on borrow.
  - o_ovf = (a[MSB] != b[MSB]) & (o_res[MSB] != a[MSB]).
  - Wrap-around is modulo 2^DATA_WIDTH.
- Counter width = $clog2(DATA_WIDTH); no terminal-count aliasing when DATA_WIDTH is a power of two.
- Reset mid-operation (CALC or DONE): immediate return to IDLE with reset values; in-flight result discarded; no o_vld pulse.

Optional Feature:
- Macro: SUBTRACTOR_NBIT_SERIAL_CMP_EN.
- Defined: adds compare output ports, all gated by o_vld and reset to 0:
  - o_zero (1 bit): o_res == 0.
  - o_ltu (1 bit): equals o_brw.
  - o_lts (1 bit): o_res[MSB] ^ o_ovf.
  - Flags are registered on the CALC->DONE edge.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- W=8; a=0x05, b=0x03, brw=0 -> o_vld exactly 8 cycles after accept; o_res=0x02, o_brw=0, o_ovf=0 (CMP: zero=0, ltu=0, lts=0).
- W=8; a=0x03, b=0x05, brw=0 -> o_res=0xFE, o_brw=1, o_ovf=0 (CMP: ltu=1, lts=1).
- W=8; a=0x80, b=0x01 -> o_res=0x7F, o_brw=0, o_ovf=1 (CMP: lts=1). a=0x00, b=0x00, brw=1 -> o_res=0xFF, o_brw=1. a=0x42, b=0x42 -> o_res=0 (CMP: zero=1).
- Backpressure: hold i_rdy=0 for 5 cycles in DONE, toggle operands and assert i_vld -> o_vld stays 1, outputs stable, o_rdy=0, nothing accepted; raise i_rdy -> IDLE next edge, o_vld=0, o_rdy=1.
- Reset mid-CALC after 3 bits -> all outputs 0 and o_rdy=1 asynchronously. Then a=0x10, b=0x01 -> o_res=0x0F, o_brw=0.
- W=32 random sweep (1000 ops, random i_rdy stalls) vs golden a-b-brw model -> all o_res/o_brw/o_ovf match; accept-to-valid latency always 32.
